// File: rtl/if_pc_gen_if.sv
// ----------------------------------------------------------------------------
// if_pc_gen_if
//   Fetch-side bus between the PC generator and the fetch address stage or
//   memory.
//   req         PC generator -> memory : fetch request
//   pc_addr     PC generator -> memory : address of the current request
//   gnt         memory -> PC generator : request accepted this cycle
//   rvalid      memory -> PC generator : response beat for the oldest grant
//   rvalid_pc   PC generator -> decode : PC of the beat being answered
//   rvalid_keep PC generator -> decode : beat is not stale (qualify with rvalid)
//   The master modport is the PC generator side. The slave modport is the
//   memory/decode side.
// ----------------------------------------------------------------------------
interface if_pc_gen_if;
    logic        req;
    logic [31:0] pc_addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rvalid_pc;
    logic        rvalid_keep;

    modport master (
        output req,
        output pc_addr,
        output rvalid_pc,
        output rvalid_keep,
        input  gnt,
        input  rvalid
    );

    modport slave (
        input  req,
        input  pc_addr,
        input  rvalid_pc,
        input  rvalid_keep,
        output gnt,
        output rvalid
    );
endinterface

// File: rtl/if_pc_gen.sv
// ----------------------------------------------------------------------------
// if_pc_gen
//   This module generates the PC and tracks outstanding fetches.
//   - It produces the next instruction address from three sources: boot,
//     sequential +4, or redirect.
//   - It issues that address on a req/gnt port.
//   - It keeps a FIFO of granted PCs so that each rvalid beat is tagged with
//     its PC.
//   - When a redirect arrives, it marks the in-flight beats as stale.
//
// Ports
//   clk_i          clock; all state changes on the rising edge
//   rst_ni         asynchronous active-low reset
//   fetch_enable_i 1 = fetches may be issued
//   boot_addr_i    boot base; sampled only when leaving IDLE
//   pc_set_i       one-cycle redirect strobe
//   pc_target_i    redirect target; bits [1:0] are ignored
//   bus            fetch bus (master side): req, pc_addr, gnt, rvalid,
//                  rvalid_pc, rvalid_keep
//   busy_o         at least one granted request is still unanswered
//   proto_err_o    sticky flag: rvalid was seen while nothing was outstanding
// ----------------------------------------------------------------------------
module if_pc_gen #(
    parameter logic [31:0] BOOT_OFFSET     = 32'h80,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          fetch_enable_i,
    input  logic [31:0]   boot_addr_i,
    input  logic          pc_set_i,
    input  logic [31:0]   pc_target_i,
    if_pc_gen_if.master   bus,
    output logic          busy_o,
    output logic          proto_err_o
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [31:0]      WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [31:0]            pc_q, pc_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [31:0]            fifo_pc_q [MAX_OUTSTANDING];
    logic [31:0]            fifo_pc_d [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] stale_q, stale_d;
    logic                   proto_err_q, proto_err_d;

    logic fifo_empty;
    logic fifo_full;
    logic req;
    logic push;
    logic pop;
    logic redirect;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake decode
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FULL_CNT);
        // When the FIFO is full, req is held low, so any gnt in that cycle is ignored.
        req        = (state_q == ST_RUN) && !fifo_full;
        push       = req && bus.gnt;
        pop        = bus.rvalid && !fifo_empty;
        redirect   = pc_set_i && (state_q != ST_IDLE);
    end

    // Next-state logic for the FSM, the PC and the FIFO
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        fifo_pc_d   = fifo_pc_q;
        stale_d     = stale_q;
        proto_err_d = proto_err_q | (bus.rvalid & fifo_empty);

        case (state_q)
            ST_IDLE: if (fetch_enable_i) state_d = ST_RUN;
            ST_RUN:  if (!fetch_enable_i) state_d = ST_HALT;
            ST_HALT: if (fetch_enable_i) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase

        // A redirect takes priority over the +4 step. A beat granted in the
        // same cycle as a redirect belongs to the old path.
        if (state_q == ST_IDLE) begin
            if (fetch_enable_i) pc_d = (boot_addr_i & WORD_MASK) + BOOT_OFFSET;
        end else if (redirect) begin
            pc_d = pc_target_i & WORD_MASK;
        end else if (push) begin
            pc_d = pc_q + 32'd4;
        end

        // The stale bits are updated before the push, so that the new entry gets
        // its own stale value. A head popped in this cycle is reported from the
        // registered bits, which still hold the pre-redirect value.
        if (redirect) stale_d = '1;

        if (push) begin
            fifo_pc_d[wr_ptr_q] = pc_q;
            stale_d[wr_ptr_q]   = redirect;
            wr_ptr_d            = ptr_inc(wr_ptr_q);
        end

        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            proto_err_q <= proto_err_d;
        end
    end

    // FIFO storage: one PC and one stale bit per slot
    for (genvar gi = 0; gi < int'(MAX_OUTSTANDING); gi++) begin : g_slot
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                fifo_pc_q[gi] <= '0;
                stale_q[gi]   <= 1'b0;
            end else begin
                fifo_pc_q[gi] <= fifo_pc_d[gi];
                stale_q[gi]   <= stale_d[gi];
            end
        end
    end

    // The head outputs are forced to zero when the FIFO is empty, so they read
    // as zero after reset.
    assign bus.req         = req;
    assign bus.pc_addr     = pc_q;
    assign bus.rvalid_pc   = fifo_empty ? '0 : fifo_pc_q[rd_ptr_q];
    assign bus.rvalid_keep = !fifo_empty && !stale_q[rd_ptr_q];
    assign busy_o          = !fifo_empty;
    assign proto_err_o     = proto_err_q;

endmodule
